// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback stage and the load-path merge.
package alu_writeback_pkg;

   localparam int unsigned REG_W     = 64;
   localparam int unsigned RF_ADDR_W = 4;
   localparam int unsigned WB_DEPTH  = 2;

   typedef logic [REG_W-1:0] reg_t;

   // Operand width of a micro-instruction
   typedef enum logic [1:0] {
      BMD_08 = 2'd0,
      BMD_16 = 2'd1,
      BMD_32 = 2'd2,
      BMD_64 = 2'd3
   } bmd_t;

   localparam int unsigned EFLAGS_CF = 0;
   localparam int unsigned EFLAGS_PF = 2;
   localparam int unsigned EFLAGS_AF = 4;
   localparam int unsigned EFLAGS_ZF = 6;
   localparam int unsigned EFLAGS_SF = 7;
   localparam int unsigned EFLAGS_TF = 8;
   localparam int unsigned EFLAGS_IF = 9;
   localparam int unsigned EFLAGS_DF = 10;
   localparam int unsigned EFLAGS_OF = 11;

   // Bit 1 of EFLAGS is reserved and always reads as one
   localparam reg_t EFLAGS_RESET_VALUE = 64'h2;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      reg_t                 data;
   } wb_entry_t;

endpackage

// File: rtl/alu_writeback_merge.sv
// x86 partial-register merge: narrow writes keep upper bits, 32-bit writes zero-extend.
module partial_reg_merge
   import alu_writeback_pkg::*;
(
   input  bmd_t bmd,
   input  reg_t d,
   input  reg_t old,
   output reg_t merged_c
);

   always_comb begin
      merged_c = d;
      unique case (bmd)
         BMD_08:  merged_c = {old[REG_W-1:8],  d[7:0]};
         BMD_16:  merged_c = {old[REG_W-1:16], d[15:0]};
         BMD_32:  merged_c = {32'b0, d[31:0]};
         BMD_64:  merged_c = d;
      endcase
   end

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: partial-register merge, register-file write FIFO, EFLAGS.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_W-1:0]     in_d,
   input  logic [REG_W-1:0]     in_eflags,
   input  logic                 in_eflags_update,
   input  bmd_t                 in_bmd,
   input  logic [RF_ADDR_W-1:0] in_rd,
   input  logic                 in_rd_we,
   input  logic [REG_W-1:0]     in_rd_old,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [RF_ADDR_W-1:0] wb_addr,
   output logic [REG_W-1:0]     wb_data,
   output logic [REG_W-1:0]     eflags,
   output logic [REG_W-1:0]     eflags_as_src
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        mem   [DEPTH];
   wb_entry_t        mem_n [DEPTH];
   wb_entry_t        head;
   wb_entry_t        head_n;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
   logic [CNT_W-1:0] count, count_n;
   reg_t             eflags_q, eflags_n;
   reg_t             merged_c;
   logic             accept_c, enq_c, deq_c;

   partial_reg_merge u_merge (
      .bmd      (in_bmd),
      .d        (in_d),
      .old      (in_rd_old),
      .merged_c (merged_c)
   );

   // Next-state: flush wins over any enqueue/dequeue but not over the EFLAGS commit
   always_comb begin
      accept_c = in_valid & in_ready;
      enq_c    = accept_c & in_rd_we;
      deq_c    = wb_valid & wb_ready;
      mem_n    = mem;
      rd_ptr_n = rd_ptr;
      wr_ptr_n = wr_ptr;
      count_n  = count;
      eflags_n = eflags_q;

      if (accept_c && in_eflags_update) begin
         eflags_n = in_eflags;
      end

      if (flush) begin
         rd_ptr_n = '0;
         wr_ptr_n = '0;
         count_n  = '0;
      end else begin
         if (enq_c) begin
            mem_n[wr_ptr] = '{addr: in_rd, data: merged_c};
            wr_ptr_n      = wr_ptr + PTR_W'(1);
         end
         if (deq_c) begin
            rd_ptr_n = rd_ptr + PTR_W'(1);
         end
         unique case ({enq_c, deq_c})
            2'b10:   count_n = count + CNT_W'(1);
            2'b01:   count_n = count - CNT_W'(1);
            default: count_n = count;
         endcase
      end

      // Head is pre-selected so wb_* come straight from flops
      head_n = mem_n[rd_ptr_n];
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         head     <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         eflags_q <= EFLAGS_RESET_VALUE;
         wb_valid <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         mem      <= mem_n;
         head     <= head_n;
         rd_ptr   <= rd_ptr_n;
         wr_ptr   <= wr_ptr_n;
         count    <= count_n;
         eflags_q <= eflags_n;
         wb_valid <= (count_n != '0);
         in_ready <= (count_n < CNT_W'(DEPTH));
      end
   end

   assign wb_addr       = head.addr;
   assign wb_data       = head.data;
   assign eflags        = eflags_q;
   assign eflags_as_src = eflags_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table plus multi-cycle FIFO/flush/reset sequences.
module tb_alu_writeback;
   import alu_writeback_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic [REG_W-1:0]     in_d;
   logic [REG_W-1:0]     in_eflags;
   logic                 in_eflags_update;
   bmd_t                 in_bmd;
   logic [RF_ADDR_W-1:0] in_rd;
   logic                 in_rd_we;
   logic [REG_W-1:0]     in_rd_old;
   logic                 wb_valid;
   logic                 wb_ready;
   logic [RF_ADDR_W-1:0] wb_addr;
   logic [REG_W-1:0]     wb_data;
   logic [REG_W-1:0]     eflags;
   logic [REG_W-1:0]     eflags_as_src;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bmd_t        bmd;
      logic [63:0] d;
      logic [63:0] old;
      logic [3:0]  rd;
      logic        we;
      logic        upd;
      logic [63:0] fl;
      logic        exp_valid;
      logic [63:0] exp_data;
      logic [63:0] exp_eflags;
   } vec_t;

   vec_t vecs [6];

   alu_writeback dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_d             (in_d),
      .in_eflags        (in_eflags),
      .in_eflags_update (in_eflags_update),
      .in_bmd           (in_bmd),
      .in_rd            (in_rd),
      .in_rd_we         (in_rd_we),
      .in_rd_old        (in_rd_old),
      .wb_valid         (wb_valid),
      .wb_ready         (wb_ready),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data),
      .eflags           (eflags),
      .eflags_as_src    (eflags_as_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bmd_t bmd, input logic [63:0] d, input logic [63:0] old,
                       input logic [3:0] rd, input logic we, input logic upd,
                       input logic [63:0] fl);
      in_valid         = 1'b1;
      in_bmd           = bmd;
      in_d             = d;
      in_rd_old        = old;
      in_rd            = rd;
      in_rd_we         = we;
      in_eflags_update = upd;
      in_eflags        = fl;
   endtask

   task automatic idle();
      in_valid         = 1'b0;
      in_eflags_update = 1'b0;
      in_rd_we         = 1'b0;
   endtask

   initial begin
      vecs[0] = '{BMD_08, 64'hFFFF_FFFF_FFFF_FFAB, 64'h1122_3344_5566_7788, 4'd3, 1'b1, 1'b0,
                  64'h0, 1'b1, 64'h1122_3344_5566_77AB, 64'h2};
      vecs[1] = '{BMD_32, 64'hFFFF_FFFF_8000_0001, 64'h5555_5555_5555_5555, 4'd5, 1'b1, 1'b1,
                  64'h1, 1'b1, 64'h0000_0000_8000_0001, 64'h1};
      vecs[2] = '{BMD_16, 64'hFFFF_FFFF_FFFF_1234, 64'hAAAA_AAAA_AAAA_AAAA, 4'd7, 1'b1, 1'b0,
                  64'h0, 1'b1, 64'hAAAA_AAAA_AAAA_1234, 64'h1};
      vecs[3] = '{BMD_64, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 4'd15, 1'b1, 1'b1,
                  64'h8D5, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'h8D5};
      vecs[4] = '{BMD_64, 64'h1, 64'h0, 4'd2, 1'b0, 1'b1,
                  64'h41, 1'b0, 64'h0, 64'h41};
      vecs[5] = '{BMD_64, 64'h1, 64'h0, 4'd2, 1'b0, 1'b0,
                  64'hFFFF, 1'b0, 64'h0, 64'h41};

      // Reset held while a write is presented
      rst      = 1'b1;
      flush    = 1'b0;
      wb_ready = 1'b1;
      push(BMD_64, 64'h99, 64'h0, 4'd9, 1'b1, 1'b1, 64'hFF);
      repeat (3) step();
      check("reset eflags", eflags, 64'h2);
      check("reset wb_valid", 64'(wb_valid), 64'h0);
      check("reset wb_addr", 64'(wb_addr), 64'h0);
      check("reset wb_data", wb_data, 64'h0);
      rst = 1'b0;
      idle();
      step();
      check("post-reset in_ready", 64'(in_ready), 64'h1);
      check("post-reset wb_valid", 64'(wb_valid), 64'h0);
      check("post-reset eflags_as_src", eflags_as_src, 64'h2);

      // Table: one transaction each, drained immediately
      for (int i = 0; i < 6; i++) begin
         push(vecs[i].bmd, vecs[i].d, vecs[i].old, vecs[i].rd, vecs[i].we, vecs[i].upd, vecs[i].fl);
         step();
         idle();
         check($sformatf("vec%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d wb_addr", i), 64'(wb_addr), 64'(vecs[i].rd));
            check($sformatf("vec%0d wb_data", i), wb_data, vecs[i].exp_data);
         end
         check($sformatf("vec%0d eflags", i), eflags, vecs[i].exp_eflags);
         step();
         check($sformatf("vec%0d drained", i), 64'(wb_valid), 64'h0);
      end

      // Backpressure: fill, blocked third push, ordered drain
      wb_ready = 1'b0;
      push(BMD_64, 64'h111, 64'h0, 4'd1, 1'b1, 1'b0, 64'h0);
      step();
      check("bp first in_ready", 64'(in_ready), 64'h1);
      check("bp first wb_addr", 64'(wb_addr), 64'd1);
      push(BMD_64, 64'h222, 64'h0, 4'd2, 1'b1, 1'b0, 64'h0);
      step();
      check("bp full in_ready", 64'(in_ready), 64'h0);
      check("bp hold wb_addr", 64'(wb_addr), 64'd1);
      push(BMD_64, 64'h999, 64'h0, 4'd9, 1'b1, 1'b1, 64'h777);
      step();
      check("bp blocked in_ready", 64'(in_ready), 64'h0);
      check("bp blocked wb_data", wb_data, 64'h111);
      check("bp blocked eflags", eflags, 64'h41);
      idle();
      wb_ready = 1'b1;
      step();
      check("bp pop1 wb_addr", 64'(wb_addr), 64'd2);
      check("bp pop1 wb_data", wb_data, 64'h222);
      check("bp pop1 in_ready", 64'(in_ready), 64'h1);
      step();
      check("bp pop2 wb_valid", 64'(wb_valid), 64'h0);

      // Simultaneous enqueue and dequeue at count=1
      wb_ready = 1'b0;
      push(BMD_64, 64'h444, 64'h0, 4'd4, 1'b1, 1'b0, 64'h0);
      step();
      wb_ready = 1'b1;
      push(BMD_64, 64'h666, 64'h0, 4'd6, 1'b1, 1'b0, 64'h0);
      step();
      idle();
      check("simul wb_valid", 64'(wb_valid), 64'h1);
      check("simul wb_addr", 64'(wb_addr), 64'd6);
      check("simul in_ready", 64'(in_ready), 64'h1);
      step();
      check("simul drained", 64'(wb_valid), 64'h0);

      // Flush with a simultaneous push that also updates EFLAGS
      wb_ready = 1'b0;
      push(BMD_64, 64'hAA, 64'h0, 4'd10, 1'b1, 1'b0, 64'h0);
      step();
      check("flush pre wb_valid", 64'(wb_valid), 64'h1);
      flush = 1'b1;
      push(BMD_64, 64'hBB, 64'h0, 4'd11, 1'b1, 1'b1, 64'h80);
      step();
      flush = 1'b0;
      idle();
      check("flush wb_valid", 64'(wb_valid), 64'h0);
      check("flush in_ready", 64'(in_ready), 64'h1);
      check("flush eflags", eflags, 64'h80);
      step();
      check("flush stays empty", 64'(wb_valid), 64'h0);
      push(BMD_08, 64'h12, 64'hFFFF_FFFF_FFFF_FF00, 4'd12, 1'b1, 1'b0, 64'h0);
      step();
      idle();
      check("post-flush wb_addr", 64'(wb_addr), 64'd12);
      check("post-flush wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF12);

      // Reset mid-operation drops the buffered write
      #1;
      rst = 1'b1;
      #1;
      check("async reset wb_valid", 64'(wb_valid), 64'h0);
      check("async reset eflags", eflags, 64'h2);
      step();
      rst      = 1'b0;
      wb_ready = 1'b1;
      step();
      check("after reset wb_valid", 64'(wb_valid), 64'h0);
      check("after reset in_ready", 64'(in_ready), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-to-writeback stage directly downstream of the ALU.
- Accepts each ALU result (d, eflags, eflags_update) together with destination info.
- Performs the x86 partial-register merge, buffers register-file writes in a 2-entry FIFO, and holds the architected EFLAGS register.
- Drives eflags_as_src back into the ALU.

Parameters:
- REG_W, 64, datapath and EFLAGS width
- RF_ADDR_W, 4, GPR index width (16 GPRs)
- DEPTH, 2, write-FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  drop all buffered writes
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_d  in  REG_W  ALU result d
- in_eflags  in  REG_W  ALU eflags output
- in_eflags_update  in  1  commit in_eflags
- in_bmd  in  bmd_t  operand width of the micro-instruction
- in_rd  in  RF_ADDR_W  destination register
- in_rd_we  in  1  destination write enable (0 for CMP/TEST)
- in_rd_old  in  REG_W  current destination value, used for merging
- wb_valid  out  1  register-file write pending
- wb_ready  in  1  register file takes the write
- wb_addr  out  RF_ADDR_W  write address
- wb_data  out  REG_W  merged write data
- eflags  out  REG_W  architected EFLAGS (registered)
- eflags_as_src  out  REG_W  EFLAGS to the ALU; equals eflags

Behaviour:
- **Reset** (async, rst=1):
  - FIFO count, rd_ptr, wr_ptr = 0.
  - wb_valid=0, wb_addr=0, wb_data=0.
  - eflags=64'h2 (reserved bit 1 set).
  - in_ready=1 after release.
- **in_ready** = (count<DEPTH). It is a function of registered count only and never depends on wb_ready.
- **accept** = in_valid & in_ready.
- **EFLAGS**: on accept with in_eflags_update=1, eflags <= in_eflags at the next edge.
  - Applies regardless of in_rd_we.
  - eflags_as_src is purely registered, so there is no combinational path through the ALU.
  - A back-to-back ADC after ADD sees the updated CF from the next cycle.
- **Merge** (computed at accept):
  - BMD_08: {in_rd_old[63:8], in_d[7:0]}
  - BMD_16: {in_rd_old[63:16], in_d[15:0]}
  - BMD_32: {32'b0, in_d[31:0]}
  - BMD_64: in_d
- **Enqueue**: on accept with in_rd_we=1, write {in_rd, merged} at wr_ptr and increment wr_ptr (wraps mod DEPTH). Accept with in_rd_we=0 enqueues nothing.
- **Dequeue**:
  - wb_valid = (count!=0).
  - wb_addr and wb_data come from the entry at rd_ptr (storage registers).
  - When wb_valid & wb_ready, increment rd_ptr.
- **Latency**: accept at edge N makes the entry visible on wb_* after edge N (one cycle).
- **wb_* stability**: wb_* holds steady while wb_valid=1 and wb_ready=0.
- **Simultaneous enqueue and dequeue**: count unchanged. Valid at any count<DEPTH; at count=DEPTH no enqueue is possible.
- **flush** (sync, highest priority):
  - count=0 and rd_ptr=wr_ptr=0 next cycle.
  - An enqueue and a dequeue in the same cycle are both discarded.
  - An EFLAGS update from an accept in the flush cycle still commits.
- **Ordering**: writes leave in acceptance order. No coalescing of the same rd.
- **Reset mid-operation**: all buffered writes are lost. No wb pulse is emitted.

Decomposition:
- Shared package holds:
  - bmd_t and its BMD_08/16/32/64 literals.
  - reg_t.
  - EFLAGS_* bit indices.
  - EFLAGS_RESET_VALUE = 64'h2.
  - A wb_entry_t struct {addr, data}.
- One sub-module: partial_reg_merge. It is combinational: (bmd, d, old) -> merged. It is reused by the load path later.
- FIFO and EFLAGS register stay inline.

Test Plan:
- **Reset value**: hold rst with in_valid=1 -> eflags=64'h2, wb_valid=0, in_ready=1 on release, no FIFO entry.
- **BMD_08 merge**: in_bmd=BMD_08, in_d=64'hFFFF_FFFF_FFFF_FFAB, in_rd_old=64'h1122_3344_5566_7788, rd=3, we=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=64'h1122_3344_5566_77AB.
- **BMD_32 zero-extend**: in_d=64'hFFFF_FFFF_8000_0001 -> wb_data=64'h0000_0000_8000_0001. **BMD_16**: old=64'hAAAA_AAAA_AAAA_AAAA, d=16'h1234 -> 64'hAAAA_AAAA_AAAA_1234.
- **Backpressure and ordering**: wb_ready=0, push rd=1 then rd=2 -> in_ready=0 and third push not accepted; then wb_ready=1 -> writes retire rd=1 then rd=2 in order, in_ready returns to 1 after first pop.
- **CMP-style flag-only update**: in_rd_we=0, in_eflags_update=1, in_eflags=64'h41 -> no wb_valid, eflags=64'h41 next cycle. Repeating with in_eflags_update=0 leaves eflags unchanged.
- **Flush with push**: one entry queued, flush=1 with simultaneous push (we=1, eflags_update=1, eflags=64'h80) -> count=0, wb_valid=0 next cycle, eflags=64'h80.
